// File: rtl/vl_snapshot_dispatcher.sv
// vset{i}vl{i} decoder plus in-order vl/vtype snapshot queues feeding the GLSU load and store paths.
// Optional macro VL_CLUSTER_ROUNDUP_EN: round a non-clamped AVL up to a multiple of NrClusters*NrLanes.
// vtype on all ports is {vill, vma, vta, vsew[2:0], vlmul[2:0]}; the request arrives as flat valid/insn/rs1/rs2.

module vl_snapshot_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             ack_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    pop      = ack_i && (cnt_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == CntW'(Depth));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (cnt_q != '0);
  assign full_o  = full_q;

`ifndef SYNTHESIS
  ack_on_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) ack_i |-> (cnt_q != '0))
    else $warning("addrgen ack with empty snapshot queue ignored");
`endif
endmodule

module vl_snapshot_dispatcher #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned NrClusters   = 4,
  parameter int unsigned LdQueueDepth = 4,
  parameter int unsigned StQueueDepth = 4,
  parameter int unsigned VLENB        = 128,
  parameter int unsigned ELENB        = 8,
  parameter int unsigned VlWidth      = $clog2(VLENB * NrClusters * 8 + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               acc_req_valid_i,
  input  logic [31:0]        acc_req_insn_i,
  input  logic [63:0]        acc_req_rs1_i,
  input  logic [63:0]        acc_req_rs2_i,
  output logic               acc_req_ready_o,
  input  logic               ar_addrgen_ack_i,
  input  logic               aw_addrgen_ack_i,
  output logic [VlWidth-1:0] vl_ld_o,
  output logic [8:0]         vtype_ld_o,
  output logic               ld_valid_o,
  output logic [VlWidth-1:0] vl_st_o,
  output logic [8:0]         vtype_st_o,
  output logic               st_valid_o,
  output logic [VlWidth-1:0] vl_o,
  output logic [8:0]         vtype_o
);
  localparam int unsigned ElenLog = $clog2(ELENB);
  localparam logic [6:0]  OpcodeLoadFp  = 7'b0000111;
  localparam logic [6:0]  OpcodeStoreFp = 7'b0100111;
  localparam logic [6:0]  OpcodeVec     = 7'b1010111;
  localparam logic [8:0]  VtypeVill     = 9'h100;
  localparam int unsigned SnapW = VlWidth + 9;

  logic [VlWidth-1:0] vl_q, vl_d;
  logic [8:0]         vtype_q, vtype_d;

  logic [6:0]         opcode;
  logic [4:0]         rs1_idx, rd_idx;
  logic               is_ld, is_st, is_cfg, is_vli, is_ivli, is_vl, req_hs;
  logic [7:0]         new_vt;
  logic [2:0]         vsew, vlmul;
  int                 lmul_s;
  logic               illegal, rs1_hi;
  logic [VlWidth-1:0] base, vlmax, avl, uimm, avl_vl;
  logic               ld_full, st_full;
  logic [SnapW-1:0]   ld_head, st_head;
  logic               unused_bits;

  assign opcode  = acc_req_insn_i[6:0];
  assign rd_idx  = acc_req_insn_i[11:7];
  assign rs1_idx = acc_req_insn_i[19:15];
  assign is_ld   = (opcode == OpcodeLoadFp);
  assign is_st   = (opcode == OpcodeStoreFp);
  assign is_cfg  = (opcode == OpcodeVec) && (acc_req_insn_i[14:12] == 3'b111);
  assign is_vli  = !acc_req_insn_i[31];
  assign is_ivli = (acc_req_insn_i[31:30] == 2'b11);
  assign is_vl   = (acc_req_insn_i[31:25] == 7'b1000000);

  // Ready looks only at registered full so an ack never combinationally reaches the CPU handshake.
  assign acc_req_ready_o = is_ld ? !ld_full : (is_st ? !st_full : 1'b1);
  assign req_hs          = acc_req_valid_i && acc_req_ready_o;

  always_comb begin
    new_vt  = is_vl ? acc_req_rs2_i[7:0] : acc_req_insn_i[27:20];
    vsew    = new_vt[5:3];
    vlmul   = new_vt[2:0];
    lmul_s  = int'($signed(vlmul));
    illegal = (vsew > 3'(ElenLog)) || (vlmul == 3'b100) || ((int'(ElenLog) + lmul_s) < int'(vsew));
    base    = VlWidth'(VLENB * NrClusters) >> vsew;
    vlmax   = vlmul[2] ? (base >> (3'd0 - vlmul)) : (base << vlmul[1:0]);
    rs1_hi  = |acc_req_rs1_i[63:VlWidth];
    avl     = acc_req_rs1_i[VlWidth-1:0];
    uimm    = VlWidth'(rs1_idx);
`ifdef VL_CLUSTER_ROUNDUP_EN
    // VLMAX is a multiple of the cluster grain, so rounding an unclamped AVL cannot exceed it.
    if ((avl % VlWidth'(NrClusters * NrLanes)) != '0)
      avl_vl = avl + VlWidth'(NrClusters * NrLanes) - (avl % VlWidth'(NrClusters * NrLanes));
    else
      avl_vl = avl;
`else
    avl_vl  = avl;
`endif
  end

  always_comb begin
    vl_d    = vl_q;
    vtype_d = vtype_q;
    if (req_hs && is_cfg && (is_vli || is_ivli || is_vl)) begin
      if (illegal) begin
        vl_d    = '0;
        vtype_d = VtypeVill;
      end else begin
        vtype_d = {1'b0, new_vt};
        if (is_ivli)                          vl_d = (uimm > vlmax) ? vlmax : uimm;
        else if (rs1_idx == '0 && rd_idx == '0) vl_d = vl_q;
        else if (rs1_idx == '0)               vl_d = vlmax;
        else if (rs1_hi || avl > vlmax)       vl_d = vlmax;
        else                                  vl_d = avl_vl;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vl_q    <= '0;
      vtype_q <= VtypeVill;
    end else begin
      vl_q    <= vl_d;
      vtype_q <= vtype_d;
    end
  end

  vl_snapshot_fifo #(.Depth(LdQueueDepth), .Width(SnapW)) i_ld_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_hs && is_ld),
    .ack_i   (ar_addrgen_ack_i),
    .data_i  ({vtype_q, vl_q}),
    .data_o  (ld_head),
    .valid_o (ld_valid_o),
    .full_o  (ld_full)
  );

  vl_snapshot_fifo #(.Depth(StQueueDepth), .Width(SnapW)) i_st_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_hs && is_st),
    .ack_i   (aw_addrgen_ack_i),
    .data_i  ({vtype_q, vl_q}),
    .data_o  (st_head),
    .valid_o (st_valid_o),
    .full_o  (st_full)
  );

  // An empty queue shows the architectural state so the GLSU always sees a sane vl/vtype.
  assign vl_ld_o    = ld_valid_o ? ld_head[VlWidth-1:0] : vl_q;
  assign vtype_ld_o = ld_valid_o ? ld_head[SnapW-1:VlWidth] : vtype_q;
  assign vl_st_o    = st_valid_o ? st_head[VlWidth-1:0] : vl_q;
  assign vtype_st_o = st_valid_o ? st_head[SnapW-1:VlWidth] : vtype_q;
  assign vl_o       = vl_q;
  assign vtype_o    = vtype_q;

  assign unused_bits = ^acc_req_rs2_i[63:8];
endmodule

// File: tb/tb_vl_snapshot_dispatcher.sv
// Bench for vl_snapshot_dispatcher: vset table, multi-cycle queue sequences, randomized run vs. reference model.
module tb_vl_snapshot_dispatcher;
  localparam logic [31:0] LD = 32'h0000_0007;
  localparam logic [31:0] ST = 32'h0000_0027;
  localparam int          QD = 4;
`ifdef VL_CLUSTER_ROUNDUP_EN
  localparam int EXP37  = 48;
  localparam int EXP100 = 112;
`else
  localparam int EXP37  = 37;
  localparam int EXP100 = 100;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        acc_req_valid_i = 1'b0;
  logic [31:0] acc_req_insn_i = '0;
  logic [63:0] acc_req_rs1_i = '0;
  logic [63:0] acc_req_rs2_i = '0;
  logic        acc_req_ready_o;
  logic        ar_addrgen_ack_i = 1'b0;
  logic        aw_addrgen_ack_i = 1'b0;
  logic [12:0] vl_ld_o, vl_st_o, vl_o;
  logic [8:0]  vtype_ld_o, vtype_st_o, vtype_o;
  logic        ld_valid_o, st_valid_o;

  always #5 clk_i = ~clk_i;

  vl_snapshot_dispatcher dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .acc_req_valid_i  (acc_req_valid_i),
    .acc_req_insn_i   (acc_req_insn_i),
    .acc_req_rs1_i    (acc_req_rs1_i),
    .acc_req_rs2_i    (acc_req_rs2_i),
    .acc_req_ready_o  (acc_req_ready_o),
    .ar_addrgen_ack_i (ar_addrgen_ack_i),
    .aw_addrgen_ack_i (aw_addrgen_ack_i),
    .vl_ld_o          (vl_ld_o),
    .vtype_ld_o       (vtype_ld_o),
    .ld_valid_o       (ld_valid_o),
    .vl_st_o          (vl_st_o),
    .vtype_st_o       (vtype_st_o),
    .st_valid_o       (st_valid_o),
    .vl_o             (vl_o),
    .vtype_o          (vtype_o)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          m_vl = 0;
  logic [8:0]  m_vt = 9'h100;
  int          ldq_vl[$], stq_vl[$];
  logic [8:0]  ldq_vt[$], stq_vt[$];
  logic        last_rdy;

  typedef struct {
    logic [31:0] insn;
    logic [63:0] rs1;
    logic [63:0] rs2;
    int          vl;
    logic [8:0]  vt;
    string       name;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [31:0] e_vli(input logic [4:0] rd, input logic [4:0] rs, input logic [7:0] vt);
    return {1'b0, 3'b000, vt, rs, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] e_ivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [7:0] vt);
    return {2'b11, 2'b00, vt, uimm, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] e_vl(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rs2);
    return {7'h40, rs2, rs, 3'b111, rd, 7'h57};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: VLMAX = VLEN_total * LMUL / SEW, legal iff SEW <= ELEN * LMUL.
  function automatic void m_cfg(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
    logic [7:0] vt;
    int sew, num, den, vlmax;
    bit ok;
    if (i[6:0] != 7'h57 || i[14:12] != 3'b111) return;
    if (!(i[31] == 1'b0 || i[31:30] == 2'b11 || i[31:25] == 7'h40)) return;
    vt  = (i[31:25] == 7'h40) ? b[7:0] : i[27:20];
    num = 1;
    den = 1;
    case (vt[2:0])
      3'd1: num = 2;
      3'd2: num = 4;
      3'd3: num = 8;
      3'd5: den = 8;
      3'd6: den = 4;
      3'd7: den = 2;
      default: ;
    endcase
    sew = 8 << vt[5:3];
    ok  = (vt[5:3] <= 3'd3) && (vt[2:0] != 3'd4) && (sew * den <= 64 * num);
    if (!ok) begin
      m_vl = 0;
      m_vt = 9'h100;
      return;
    end
    vlmax = (128 * 4 * 8 / sew) * num / den;
    m_vt  = {1'b0, vt};
    if (i[31:30] == 2'b11) m_vl = (int'(i[19:15]) > vlmax) ? vlmax : int'(i[19:15]);
    else if (i[19:15] == 5'd0) begin
      if (i[11:7] != 5'd0) m_vl = vlmax;
    end else if (a > 64'(vlmax)) m_vl = vlmax;
    else begin
      m_vl = int'(a);
`ifdef VL_CLUSTER_ROUNDUP_EN
      m_vl = ((m_vl + 15) / 16) * 16;
`endif
    end
  endfunction

  function automatic bit m_ready(input logic [31:0] i);
    if (i[6:0] == LD[6:0]) return ldq_vl.size() < QD;
    if (i[6:0] == ST[6:0]) return stq_vl.size() < QD;
    return 1'b1;
  endfunction

  task automatic check_all();
    chk("vl_o", 32'(vl_o), m_vl);
    chk("vtype_o", 32'(vtype_o), 32'(m_vt));
    chk("ld_valid", 32'(ld_valid_o), 32'(ldq_vl.size() != 0));
    chk("st_valid", 32'(st_valid_o), 32'(stq_vl.size() != 0));
    chk("vl_ld", 32'(vl_ld_o), ldq_vl.size() ? ldq_vl[0] : m_vl);
    chk("vtype_ld", 32'(vtype_ld_o), 32'(ldq_vt.size() ? ldq_vt[0] : m_vt));
    chk("vl_st", 32'(vl_st_o), stq_vl.size() ? stq_vl[0] : m_vl);
    chk("vtype_st", 32'(vtype_st_o), 32'(stq_vt.size() ? stq_vt[0] : m_vt));
  endtask

  // Entered and left at a negedge; the clock edge in between applies the request and acks.
  task automatic step(input logic v, input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                      input logic ar, input logic aw);
    bit rdy;
    acc_req_valid_i  = v;
    acc_req_insn_i   = i;
    acc_req_rs1_i    = a;
    acc_req_rs2_i    = b;
    ar_addrgen_ack_i = ar;
    aw_addrgen_ack_i = aw;
    #1;
    rdy      = m_ready(i);
    last_rdy = acc_req_ready_o;
    chk("ready", 32'(acc_req_ready_o), 32'(rdy));
    @(posedge clk_i);
    if (ar && ldq_vl.size() > 0) begin void'(ldq_vl.pop_front()); void'(ldq_vt.pop_front()); end
    if (aw && stq_vl.size() > 0) begin void'(stq_vl.pop_front()); void'(stq_vt.pop_front()); end
    if (v && rdy) begin
      if (i[6:0] == LD[6:0])      begin ldq_vl.push_back(m_vl); ldq_vt.push_back(m_vt); end
      else if (i[6:0] == ST[6:0]) begin stq_vl.push_back(m_vl); stq_vt.push_back(m_vt); end
      else m_cfg(i, a, b);
    end
    @(negedge clk_i);
    acc_req_valid_i  = 1'b0;
    ar_addrgen_ack_i = 1'b0;
    aw_addrgen_ack_i = 1'b0;
    check_all();
  endtask

  initial begin
    int pops;
    tbl[0]  = '{e_vli(5'd5, 5'd1, 8'h10), 64'd1000, 64'd0, 128, 9'h010, "e32m1_avl1000"};
    tbl[1]  = '{e_vli(5'd5, 5'd1, 8'h10), 64'd37, 64'd0, EXP37, 9'h010, "e32m1_avl37"};
    tbl[2]  = '{e_vli(5'd0, 5'd0, 8'h00), 64'd999, 64'd0, EXP37, 9'h000, "keep_vl_e8m1"};
    tbl[3]  = '{e_vli(5'd5, 5'd1, 8'h1D), 64'd50, 64'd0, 0, 9'h100, "e64mf8_vill"};
    tbl[4]  = '{e_vli(5'd1, 5'd0, 8'h03), 64'd0, 64'd0, 4096, 9'h003, "e8m8_vlmax"};
    tbl[5]  = '{e_ivli(5'd5, 5'd31, 8'h18), 64'd0, 64'd0, 31, 9'h018, "ivli_e64m1_31"};
    tbl[6]  = '{e_ivli(5'd5, 5'd20, 8'h05), 64'd0, 64'd0, 20, 9'h005, "ivli_e8mf8_20"};
    tbl[7]  = '{e_vl(5'd5, 5'd2, 5'd3), 64'h1_0000_0000, 64'hC9, 512, 9'h0C9, "vsetvl_hibits"};
    tbl[8]  = '{e_vl(5'd5, 5'd2, 5'd3), 64'd8, 64'h04, 0, 9'h100, "vsetvl_lmulrsvd"};
    tbl[9]  = '{e_vli(5'd5, 5'd1, 8'h0F), 64'd100, 64'd0, EXP100, 9'h00F, "e16mf2_avl100"};
    tbl[10] = '{e_vli(5'd5, 5'd1, 8'h28), 64'd8, 64'd0, 0, 9'h100, "sew_rsvd"};
    tbl[11] = '{e_vli(5'd5, 5'd1, 8'h1B), 64'd600, 64'd0, 512, 9'h01B, "e64m8_clamp"};
    tbl[12] = '{e_vli(5'd5, 5'd1, 8'h10), 64'd16, 64'd0, 16, 9'h010, "e32m1_avl16"};

    #12;
    chk("rst_vl", 32'(vl_o), 0);
    chk("rst_vtype", 32'(vtype_o), 32'h100);
    chk("rst_ld_valid", 32'(ld_valid_o), 0);
    chk("rst_st_valid", 32'(st_valid_o), 0);
    chk("rst_vl_ld", 32'(vl_ld_o), 0);
    chk("rst_vtype_st", 32'(vtype_st_o), 32'h100);
    chk("rst_ready", 32'(acc_req_ready_o), 1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int k = 0; k < 13; k++) begin
      step(1'b1, tbl[k].insn, tbl[k].rs1, tbl[k].rs2, 1'b0, 1'b0);
      chk({tbl[k].name, "_vl"}, 32'(vl_o), tbl[k].vl);
      chk({tbl[k].name, "_vt"}, 32'(vtype_o), 32'(tbl[k].vt));
    end

    // Loads snapshot vl across later vsets.
    step(1'b1, LD, 0, 0, 1'b0, 1'b0);
    step(1'b1, e_vli(5'd5, 5'd1, 8'h10), 64'd32, 0, 1'b0, 1'b0);
    step(1'b1, LD, 0, 0, 1'b0, 1'b0);
    step(1'b1, e_vli(5'd5, 5'd1, 8'h10), 64'd48, 0, 1'b0, 1'b0);
    step(1'b1, LD, 0, 0, 1'b0, 1'b0);
    chk("snap_head0", 32'(vl_ld_o), 16);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    chk("snap_head1", 32'(vl_ld_o), 32);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    chk("snap_head2", 32'(vl_ld_o), 48);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    chk("snap_empty_valid", 32'(ld_valid_o), 0);
    chk("snap_empty_vl", 32'(vl_ld_o), 48);

    // Illegal vtype is snapshotted as vl=0/vill.
    step(1'b1, e_vli(5'd5, 5'd1, 8'h1D), 64'd40, 0, 1'b0, 1'b0);
    step(1'b1, LD, 0, 0, 1'b0, 1'b0);
    chk("vill_snap_vl", 32'(vl_ld_o), 0);
    chk("vill_snap_vt", 32'(vtype_ld_o), 32'h100);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);

    // Fill the load queue; ready drops only for loads and returns the cycle after an ack.
    for (int k = 0; k < QD; k++) step(1'b1, LD, 0, 0, 1'b0, 1'b0);
    step(1'b1, LD, 0, 0, 1'b0, 1'b0);
    chk("full_ld_rdy", 32'(last_rdy), 0);
    step(1'b1, e_vli(5'd5, 5'd1, 8'h10), 64'd16, 0, 1'b0, 1'b0);
    chk("full_cfg_rdy", 32'(last_rdy), 1);
    step(1'b1, ST, 0, 0, 1'b0, 1'b0);
    chk("full_st_rdy", 32'(last_rdy), 1);
    step(1'b1, LD, 0, 0, 1'b1, 1'b0);
    chk("full_rdy_during_ack", 32'(last_rdy), 0);
    step(1'b1, LD, 0, 0, 1'b0, 1'b0);
    chk("rdy_after_ack", 32'(last_rdy), 1);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);

    // Both acks plus a load push in one cycle: 3 loads stay, store queue drains.
    step(1'b1, LD, 0, 0, 1'b1, 1'b1);
    chk("sim_st_valid", 32'(st_valid_o), 0);
    chk("sim_ld_valid", 32'(ld_valid_o), 1);
    pops = 0;
    for (int k = 0; k < 8 && ld_valid_o; k++) begin
      step(1'b0, 0, 0, 0, 1'b1, 1'b0);
      pops++;
    end
    chk("sim_ld_count", pops, 3);

    // Acks on empty queues change nothing.
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    chk("empty_ack_ld_valid", 32'(ld_valid_o), 0);
    chk("empty_ack_st_valid", 32'(st_valid_o), 0);
    chk("empty_ack_vl_ld", 32'(vl_ld_o), 16);
    chk("empty_ack_vt_st", 32'(vtype_st_o), 32'h010);

    for (int n = 0; n < 400; n++) begin
      int          sel;
      logic [7:0]  vt;
      logic [63:0] a;
      logic [4:0]  rd, rs;
      logic [31:0] i;
      logic        ar, aw;
      sel = int'($urandom_range(0, 9));
      vt  = {2'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
             3'($urandom_range(0, 7))};
      a   = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 5000));
      rd  = 5'($urandom_range(0, 2));
      rs  = 5'($urandom_range(0, 2));
      case (sel)
        0, 1, 2: i = LD;
        3, 4:    i = ST;
        5:       i = e_vli(rd, rs, vt);
        6:       i = e_ivli(rd, 5'($urandom_range(0, 31)), vt);
        7:       i = e_vl(rd, rs, 5'd4);
        default: i = {17'h0, 3'b000, rd, 7'h57};
      endcase
      ar = ($urandom_range(0, 2) == 0) && (ldq_vl.size() > 0);
      aw = ($urandom_range(0, 2) == 0) && (stq_vl.size() > 0);
      step(sel != 9, i, a, {$urandom, $urandom_range(0, 16777215), vt}, ar, aw);
    end

    // Reset mid-operation discards queued snapshots.
    step(1'b1, LD, 0, 0, 1'b0, 1'b0);
    step(1'b1, ST, 0, 0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #2;
    chk("midrst_ld_valid", 32'(ld_valid_o), 0);
    chk("midrst_st_valid", 32'(st_valid_o), 0);
    chk("midrst_vl", 32'(vl_o), 0);
    chk("midrst_vtype", 32'(vtype_o), 32'h100);
    rst_ni = 1'b1;
    m_vl = 0;
    m_vt = 9'h100;
    ldq_vl.delete(); ldq_vt.delete(); stq_vl.delete(); stq_vt.delete();
    @(negedge clk_i);
    step(1'b1, e_vli(5'd5, 5'd1, 8'h10), 64'd37, 0, 1'b0, 1'b0);
    chk("post_rst_vl", 32'(vl_o), EXP37);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
